// File: rtl/ctrl_pipe_regs.sv
// Control-bundle pipeline from decode through NSTAGES stages, with per-stage stall/flush,
// valid tracking, bubble insertion behind stalls and a saturating retire counter.
module ctrl_pipe_regs #(
   parameter int              CW      = 9,
   parameter int              NSTAGES = 3,
   parameter logic [CW-1:0]   BUBBLE  = '0,
   parameter int              CNTW    = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [CW-1:0]           ctrl_in,
   input  logic                    valid_in,
   input  logic [NSTAGES-1:0]      stall,
   input  logic [NSTAGES-1:0]      flush,
   output logic [NSTAGES*CW-1:0]   ctrl_out,
   output logic [NSTAGES-1:0]      valid_out,
   output logic                    in_ready,
   output logic [CNTW-1:0]         retire_cnt
);

   logic [NSTAGES-1:0][CW-1:0] ctrl_reg;
   logic [NSTAGES-1:0][CW-1:0] ctrl_next;
   logic [NSTAGES-1:0][CW-1:0] src_ctrl;
   logic [NSTAGES-1:0]         valid_reg;
   logic [NSTAGES-1:0]         valid_next;
   logic [NSTAGES-1:0]         src_valid;
   logic [NSTAGES-1:0]         hold;
   logic [NSTAGES-1:0]         bubble_behind;
   logic [NSTAGES-1:0]         to_bubble;
   logic [CNTW-1:0]            retire_cnt_reg;
   logic                       retire_fire;

   genvar gi;
   generate
      for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
         // A stall anywhere downstream freezes this stage too.
         assign hold[gi] = |stall[NSTAGES-1:gi];

         if (gi == 0) begin : g_first
            assign src_ctrl[gi]      = valid_in ? ctrl_in : BUBBLE;
            assign src_valid[gi]     = valid_in;
            assign bubble_behind[gi] = 1'b0;
         end else begin : g_rest
            assign src_ctrl[gi]      = ctrl_reg[gi-1];
            assign src_valid[gi]     = valid_reg[gi-1];
            assign bubble_behind[gi] = hold[gi-1];
         end

         // Flush beats hold; a moving stage whose predecessor is frozen takes a bubble.
         assign to_bubble[gi]  = flush[gi] | (~hold[gi] & bubble_behind[gi]);
         assign ctrl_next[gi]  = to_bubble[gi] ? BUBBLE :
                                 hold[gi]      ? ctrl_reg[gi] : src_ctrl[gi];
         assign valid_next[gi] = to_bubble[gi] ? 1'b0 :
                                 hold[gi]      ? valid_reg[gi] : src_valid[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NSTAGES; i++) begin
            ctrl_reg[i] <= BUBBLE;
         end
         valid_reg <= '0;
      end else begin
         ctrl_reg  <= ctrl_next;
         valid_reg <= valid_next;
      end
   end

   // The bundle leaves the last stage even if that stage is flushed on the same edge.
   assign retire_fire = valid_reg[NSTAGES-1] & ~hold[NSTAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retire_cnt_reg <= '0;
      end else if (retire_fire && (retire_cnt_reg != {CNTW{1'b1}})) begin
         retire_cnt_reg <= retire_cnt_reg + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

   assign ctrl_out   = ctrl_reg;
   assign valid_out  = valid_reg;
   assign in_ready   = ~hold[0];
   assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Bench for ctrl_pipe_regs: default instance scoreboarded at retirement, a 4-bit counter
// instance sharing its stimulus, and a CW=16/NSTAGES=5 instance with a non-zero bubble.
module tb_ctrl_pipe_regs;

   localparam logic [15:0] C_BUBBLE = 16'hDEAD;

   logic        clk;
   logic        reset_n;
   logic [8:0]  ctrl_in;
   logic        valid_in;
   logic [2:0]  stall;
   logic [2:0]  flush;
   logic [26:0] ctrl_out;
   logic [2:0]  valid_out;
   logic        in_ready;
   logic [31:0] retire_cnt;

   logic [26:0] b_ctrl_out;
   logic [2:0]  b_valid_out;
   logic        b_in_ready;
   logic [3:0]  b_retire_cnt;

   logic [15:0] c_ctrl_in;
   logic        c_valid_in;
   logic [4:0]  c_stall;
   logic [4:0]  c_flush;
   logic [79:0] c_ctrl_out;
   logic [4:0]  c_valid_out;
   logic        c_in_ready;
   logic [31:0] c_retire_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [8:0]  sb_q[$];
   logic [8:0]  sb_exp;
   int unsigned exp_ret   = 0;
   int unsigned exp_ret_b = 0;

   ctrl_pipe_regs dut_a (
      .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .valid_in(valid_in),
      .stall(stall), .flush(flush), .ctrl_out(ctrl_out), .valid_out(valid_out),
      .in_ready(in_ready), .retire_cnt(retire_cnt)
   );

   ctrl_pipe_regs #(.CNTW(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .valid_in(valid_in),
      .stall(stall), .flush(flush), .ctrl_out(b_ctrl_out), .valid_out(b_valid_out),
      .in_ready(b_in_ready), .retire_cnt(b_retire_cnt)
   );

   ctrl_pipe_regs #(.CW(16), .NSTAGES(5), .BUBBLE(C_BUBBLE)) dut_c (
      .clk(clk), .reset_n(reset_n), .ctrl_in(c_ctrl_in), .valid_in(c_valid_in),
      .stall(c_stall), .flush(c_flush), .ctrl_out(c_ctrl_out), .valid_out(c_valid_out),
      .in_ready(c_in_ready), .retire_cnt(c_retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] a_slice(input int i);
      return ctrl_out[i*9 +: 9];
   endfunction

   function automatic logic [15:0] c_slice(input int i);
      return c_ctrl_out[i*16 +: 16];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted bundles pushed at the edge, popped when they leave the last stage.
   always begin
      @(posedge clk);
      if (!reset_n) begin
         sb_q.delete();
         exp_ret   = 0;
         exp_ret_b = 0;
      end else begin
         if (valid_out[2] && !stall[2]) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
               $display("FAIL retire_order: got %h leaving with nothing expected", a_slice(2));
            end else begin
               sb_exp = sb_q.pop_front();
               if (a_slice(2) !== sb_exp)
                  $display("FAIL retire_order: got %h want %h", a_slice(2), sb_exp);
               else
                  pass_cnt++;
            end
            exp_ret++;
            if (exp_ret_b != 15) exp_ret_b++;
         end
         if (valid_in && in_ready) sb_q.push_back(ctrl_in);
      end
      #1;
      total_cnt++;
      if (retire_cnt !== exp_ret) $display("FAIL retire_cnt: got %0d want %0d", retire_cnt, exp_ret);
      else pass_cnt++;
      total_cnt++;
      if (b_retire_cnt !== exp_ret_b[3:0]) $display("FAIL retire_cnt_sat: got %0d want %0d", b_retire_cnt, exp_ret_b);
      else pass_cnt++;
   end

   task automatic test_reset();
      reset_n = 1'b0; ctrl_in = '0; valid_in = 1'b0; stall = '0; flush = '0;
      c_ctrl_in = '0; c_valid_in = 1'b0; c_stall = '0; c_flush = '0;
      repeat (2) tick();
      total_cnt++;
      if (valid_out !== 3'b000) $display("FAIL reset_valid: got %b want 000", valid_out); else pass_cnt++;
      total_cnt++;
      if (ctrl_out !== 27'd0) $display("FAIL reset_ctrl: got %h want 0", ctrl_out); else pass_cnt++;
      total_cnt++;
      if (c_ctrl_out !== {5{C_BUBBLE}} || c_valid_out !== 5'b0)
         $display("FAIL reset_param: got %h/%b want %h/00000", c_ctrl_out, c_valid_out, {5{C_BUBBLE}});
      else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
      reset_n = 1'b1;
      valid_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ctrl_in = 9'h010 + 9'(i);
         tick();
      end
      valid_in = 1'b0;
      total_cnt++;
      if (valid_out !== 3'b111 || retire_cnt !== 32'd1)
         $display("FAIL pre_reset_state: got %b/%0d want 111/1", valid_out, retire_cnt);
      else pass_cnt++;
      #2;
      reset_n = 1'b0;
      #1;
      total_cnt++;
      if (valid_out !== 3'b000 || ctrl_out !== 27'd0)
         $display("FAIL async_reset_pipe: got %b/%h want 000/0", valid_out, ctrl_out);
      else pass_cnt++;
      total_cnt++;
      if (retire_cnt !== 32'd0) $display("FAIL async_reset_cnt: got %0d want 0", retire_cnt); else pass_cnt++;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_flow();
      logic [8:0] seq [3];
      seq[0] = 9'h1A3; seq[1] = 9'h055; seq[2] = 9'h1FF;
      valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ctrl_in = seq[i];
         tick();
      end
      valid_in = 1'b0; ctrl_in = '0;
      total_cnt++;
      if (a_slice(2) !== 9'h1A3 || a_slice(1) !== 9'h055 || a_slice(0) !== 9'h1FF)
         $display("FAIL flow_stages: got %h want 1ff055 order 1a3,055,1ff", ctrl_out);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (retire_cnt !== 32'd1) $display("FAIL flow_retire1: got %0d want 1", retire_cnt); else pass_cnt++;
      repeat (2) tick();
      total_cnt++;
      if (retire_cnt !== 32'd3 || valid_out !== 3'b000)
         $display("FAIL flow_retire3: got %0d/%b want 3/000", retire_cnt, valid_out);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      logic [8:0] seq [3];
      seq[0] = 9'h0C3; seq[1] = 9'h0B2; seq[2] = 9'h0A1;
      valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ctrl_in = seq[i];
         tick();
      end
      ctrl_in = 9'h0E5;
      stall = 3'b010;
      for (int c = 0; c < 2; c++) begin
         #1;
         total_cnt++;
         if (in_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", in_ready); else pass_cnt++;
         tick();
         total_cnt++;
         if (a_slice(0) !== 9'h0A1 || a_slice(1) !== 9'h0B2 || a_slice(2) !== 9'h000 || valid_out !== 3'b011)
            $display("FAIL stall_hold: got %h/%b want 000,0b2,0a1/011", ctrl_out, valid_out);
         else pass_cnt++;
      end
      stall = 3'b000;
      tick();
      valid_in = 1'b0; ctrl_in = '0;
      total_cnt++;
      if (a_slice(0) !== 9'h0E5 || a_slice(1) !== 9'h0A1 || a_slice(2) !== 9'h0B2 || valid_out !== 3'b111)
         $display("FAIL stall_resume: got %h/%b want 0b2,0a1,0e5/111", ctrl_out, valid_out);
      else pass_cnt++;
      repeat (3) tick();
   endtask

   task automatic test_flush();
      valid_in = 1'b1; ctrl_in = 9'h111;
      tick();
      ctrl_in = 9'h122; flush = 3'b001;
      tick();
      void'(sb_q.pop_back());
      total_cnt++;
      if (valid_out !== 3'b010 || a_slice(0) !== 9'h000 || a_slice(1) !== 9'h111)
         $display("FAIL flush_s0: got %h/%b want 000,111,000/010", ctrl_out, valid_out);
      else pass_cnt++;
      flush = 3'b000; ctrl_in = 9'h133;
      tick();
      ctrl_in = 9'h144;
      tick();
      valid_in = 1'b0; ctrl_in = '0; stall = 3'b010; flush = 3'b010;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL flush_stall_ready: got %b want 0", in_ready); else pass_cnt++;
      tick();
      void'(sb_q.pop_front());
      total_cnt++;
      if (valid_out !== 3'b001 || a_slice(0) !== 9'h144 || a_slice(1) !== 9'h000 || a_slice(2) !== 9'h000)
         $display("FAIL flush_stall_s1: got %h/%b want 000,000,144/001", ctrl_out, valid_out);
      else pass_cnt++;
      stall = 3'b000; flush = 3'b000;
      repeat (3) tick();
      total_cnt++;
      if (sb_q.size() != 0) $display("FAIL flush_drain: got %0d pending want 0", sb_q.size()); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      valid_in = 1'b1;
      for (int i = 0; i < 17; i++) begin
         ctrl_in = 9'((i * 7 + 1) & 9'h1FF);
         tick();
      end
      valid_in = 1'b0; ctrl_in = '0;
      repeat (3) tick();
      total_cnt++;
      if (b_retire_cnt !== 4'hF) $display("FAIL sat_final: got %h want f", b_retire_cnt); else pass_cnt++;
      total_cnt++;
      if (retire_cnt !== 32'd17) $display("FAIL b2b_count: got %0d want 17", retire_cnt); else pass_cnt++;
   endtask

   task automatic test_param();
      c_ctrl_in = 16'h1234; c_valid_in = 1'b1;
      tick();
      c_ctrl_in = '0; c_valid_in = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 5; j++) begin
            total_cnt++;
            if (c_slice(j) !== ((j == k) ? 16'h1234 : C_BUBBLE))
               $display("FAIL param_stage%0d_at%0d: got %h want %h", j, k, c_slice(j), (j == k) ? 16'h1234 : C_BUBBLE);
            else pass_cnt++;
         end
         total_cnt++;
         if (c_valid_out !== 5'(1 << k)) $display("FAIL param_valid_at%0d: got %b want %b", k, c_valid_out, 5'(1 << k));
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if (c_retire_cnt !== 32'd1) $display("FAIL param_retire: got %0d want 1", c_retire_cnt); else pass_cnt++;
      c_stall = 5'b10000;
      #1;
      total_cnt++;
      if (c_in_ready !== 1'b0) $display("FAIL param_stall_prop: got %b want 0", c_in_ready); else pass_cnt++;
      c_stall = '0;
   endtask

   initial begin
      test_reset();
      test_flow();
      test_stall();
      test_flush();
      test_back_to_back();
      test_param();
      total_cnt++;
      if (sb_q.size() != 0) $display("FAIL final_drain: got %0d pending want 0", sb_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
